// File: rtl/adc_sample_scheduler_pkg.sv
// adc_sched_pkg: shared state encoding, default parameters and width helper for the ADC scheduler
package adc_sched_pkg;
  localparam int DEF_CLK_PER_SAMPLE    = 1024;
  localparam int DEF_SAMPLES_PER_SEC   = 3200;
  localparam int DEF_SAMPLES_PER_CYCLE = 64;
  localparam int DEF_CONVST_CYCLES     = 4;
  localparam int DEF_BUSY_TIMEOUT      = 128;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_WAIT_PPS  = 3'd1;
  localparam state_t S_ARMED     = 3'd2;
  localparam state_t S_CONV      = 3'd3;
  localparam state_t S_BUSY_WAIT = 3'd4;
  localparam state_t S_READ      = 3'd5;
  function automatic int index_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int INDEX_W = index_w(DEF_SAMPLES_PER_SEC);
endpackage

// File: rtl/adc_sample_scheduler_if.sv
// adc_sample_scheduler_if: ADC handshake and sample-report bundle between scheduler and front end
interface adc_sample_scheduler_if
  import adc_sched_pkg::*;
#(
  parameter int IW = INDEX_W
);
  logic          adc_busy;
  logic          adc_read_done;
  logic          convst;
  logic          adc_read_req;
  logic          sample_strobe;
  logic [IW-1:0] sample_index;
  logic          pulse_50_hz;
  logic          locked;
  logic          overrun_err;
  logic          timeout_err;
  modport master (
    input  adc_busy, adc_read_done,
    output convst, adc_read_req, sample_strobe, sample_index, pulse_50_hz, locked, overrun_err, timeout_err
  );
  modport slave (
    output adc_busy, adc_read_done,
    input  convst, adc_read_req, sample_strobe, sample_index, pulse_50_hz, locked, overrun_err, timeout_err
  );
endinterface

// File: rtl/adc_sample_scheduler_tick.sv
// sample_tick_generator: PPS-realigned sample tick, per-second index, 50 Hz sub-counter and lock flag
module sample_tick_generator
  import adc_sched_pkg::*;
#(
  parameter int CLK_PER_SAMPLE    = DEF_CLK_PER_SAMPLE,
  parameter int SAMPLES_PER_SEC   = DEF_SAMPLES_PER_SEC,
  parameter int SAMPLES_PER_CYCLE = DEF_SAMPLES_PER_CYCLE
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_enable,
  input  logic                                  i_pps,
  output logic                                  o_tick,
  output logic [index_w(SAMPLES_PER_SEC)-1:0]   o_index_next,
  output logic                                  o_cyc_zero_next,
  output logic                                  o_locked
);
  localparam int TW = index_w(CLK_PER_SAMPLE);
  localparam int IW = index_w(SAMPLES_PER_SEC);
  localparam int YW = index_w(SAMPLES_PER_CYCLE);
  logic [TW-1:0] r_tick_cnt;
  logic [IW-1:0] r_index;
  logic [YW-1:0] r_cyc;
  logic          r_locked;
  logic          w_tick, w_wrap;
  logic [IW-1:0] w_index_next;
  logic [YW-1:0] w_cyc_next;
  assign w_tick       = i_pps || r_tick_cnt == TW'(CLK_PER_SAMPLE - 1);
  assign w_wrap       = r_index == IW'(SAMPLES_PER_SEC - 1);
  assign w_index_next = (i_pps || w_wrap) ? '0 : r_index + 1'b1;
  assign w_cyc_next   = (i_pps || w_wrap || r_cyc == YW'(SAMPLES_PER_CYCLE - 1)) ? '0 : r_cyc + 1'b1;
  assign o_tick          = w_tick;
  assign o_index_next    = w_index_next;
  assign o_cyc_zero_next = w_cyc_next == '0;
  assign o_locked        = r_locked;
  // Free-running sample grid; PPS restarts it, a wrap without PPS means holdover
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
      r_index    <= '0;
      r_cyc      <= '0;
      r_locked   <= 1'b0;
    end else if (!i_enable) begin
      r_tick_cnt <= '0;
      r_index    <= '0;
      r_cyc      <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) begin
        r_index <= w_index_next;
        r_cyc   <= w_cyc_next;
      end
      if (i_pps) r_locked <= 1'b1;
      else if (w_tick && w_wrap) r_locked <= 1'b0;
    end
endmodule

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: PPS-aligned ADC conversion sequencer with CONVST/busy/read handshake
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int CLK_PER_SAMPLE    = DEF_CLK_PER_SAMPLE,
  parameter int SAMPLES_PER_SEC   = DEF_SAMPLES_PER_SEC,
  parameter int SAMPLES_PER_CYCLE = DEF_SAMPLES_PER_CYCLE,
  parameter int CONVST_CYCLES     = DEF_CONVST_CYCLES,
  parameter int BUSY_TIMEOUT      = DEF_BUSY_TIMEOUT
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic                   i_pps_posedge,
  adc_sample_scheduler_if.master bus
);
  localparam int IW = index_w(SAMPLES_PER_SEC);
  localparam int CW = index_w(BUSY_TIMEOUT > CONVST_CYCLES ? BUSY_TIMEOUT : CONVST_CYCLES);
  logic          w_tick, w_cyc_zero_next, w_locked, w_inflight, w_start;
  logic [IW-1:0] w_index_next, r_sample_index;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic          r_convst, r_req, r_strobe, r_pulse, r_overrun, r_timeout;
  sample_tick_generator #(
    .CLK_PER_SAMPLE   (CLK_PER_SAMPLE),
    .SAMPLES_PER_SEC  (SAMPLES_PER_SEC),
    .SAMPLES_PER_CYCLE(SAMPLES_PER_CYCLE)
  ) u_tick (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_pps          (i_pps_posedge),
    .o_tick         (w_tick),
    .o_index_next   (w_index_next),
    .o_cyc_zero_next(w_cyc_zero_next),
    .o_locked       (w_locked)
  );
  assign w_inflight = r_state inside {S_CONV, S_BUSY_WAIT, S_READ};
  assign w_start    = r_state != S_IDLE && (i_pps_posedge || (w_tick && r_state == S_ARMED));
  assign bus.convst        = r_convst;
  assign bus.adc_read_req  = r_req;
  assign bus.sample_strobe = r_strobe;
  assign bus.sample_index  = r_sample_index;
  assign bus.pulse_50_hz   = r_pulse;
  assign bus.locked        = w_locked;
  assign bus.overrun_err   = r_overrun;
  assign bus.timeout_err   = r_timeout;
  // Sample FSM; a PPS aborts whatever is in flight and restarts at index 0
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_sample_index <= '0;
      r_convst       <= 1'b0;
      r_req          <= 1'b0;
      r_strobe       <= 1'b0;
      r_pulse        <= 1'b0;
      r_overrun      <= 1'b0;
      r_timeout      <= 1'b0;
    end else if (!i_enable) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_sample_index <= '0;
      r_convst       <= 1'b0;
      r_req          <= 1'b0;
      r_strobe       <= 1'b0;
      r_pulse        <= 1'b0;
      r_overrun      <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_pulse  <= 1'b0;
      if (w_tick && !i_pps_posedge && w_inflight) r_overrun <= 1'b1;
      if (w_start) begin
        r_state        <= S_CONV;
        r_cnt          <= '0;
        r_convst       <= 1'b1;
        r_req          <= 1'b0;
        r_sample_index <= w_index_next;
        r_pulse        <= w_cyc_zero_next;
      end else if (r_state == S_IDLE) begin
        r_state <= S_WAIT_PPS;
      end else if (r_state == S_CONV) begin
        r_cnt <= r_cnt == CW'(CONVST_CYCLES - 1) ? '0 : r_cnt + 1'b1;
        if (r_cnt == CW'(CONVST_CYCLES - 1)) begin
          r_convst <= 1'b0;
          r_state  <= S_BUSY_WAIT;
        end
      end else if (r_state == S_BUSY_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
        if (!bus.adc_busy) begin
          r_state <= S_READ;
          r_req   <= 1'b1;
        end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          r_timeout <= 1'b1;
          r_state   <= S_ARMED;
        end
      end else if (r_state == S_READ && bus.adc_read_done) begin
        r_req    <= 1'b0;
        r_strobe <= 1'b1;
        r_state  <= S_ARMED;
      end
    end
endmodule
